// File: rtl/simple_processor_pkg.sv
// Shared types and widths for the simple processor core.
package simple_processor_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    FUNC_ADDI  = 3'd0,
    FUNC_ADD   = 3'd1,
    FUNC_SUB   = 3'd2,
    FUNC_AND   = 3'd3,
    FUNC_OR    = 3'd4,
    FUNC_XOR   = 3'd5,
    FUNC_LOAD  = 3'd6,
    FUNC_STORE = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } math_ctrl_state_t;

  // True for the operations handled by the integer math path.
  function automatic logic is_math_func(input func_t f);
    return (f == FUNC_ADDI) || (f == FUNC_ADD) || (f == FUNC_SUB);
  endfunction

endpackage

// File: rtl/math_exec_ctrl_alu_math.sv
// Combinational ADDI/ADD/SUB unit; arithmetic wraps modulo 2^DATA_WIDTH.
module alu_math
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned IMM_WIDTH  = 6
) (
  input  func_t                 func,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [IMM_WIDTH-1:0]  imm,
  output logic [DATA_WIDTH-1:0] result_c
);

  logic [DATA_WIDTH-1:0] imm_ext;

  assign imm_ext = {{(DATA_WIDTH - IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};

  always_comb begin
    result_c = '0;
    case (func)
      FUNC_ADDI: result_c = a + imm_ext;
      FUNC_ADD:  result_c = a + b;
      FUNC_SUB:  result_c = a - b;
      default:   result_c = '0;
    endcase
  end

endmodule

// File: rtl/math_exec_ctrl.sv
// Execute-stage sequencer: decode handshake -> RF read -> alu_math -> RF writeback.
module math_exec_ctrl
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = simple_processor_pkg::REG_ADDR_WIDTH,
  parameter int unsigned IMM_WIDTH      = 6
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  func_t                     func_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [IMM_WIDTH-1:0]      imm_i,
  output logic                      rf_rd_en_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]     rf_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rf_rs2_data_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      illegal_o,
  output logic                      busy_o,
  output logic [31:0]               retired_count_o
);

  localparam int unsigned CNT_WIDTH = 32;

  math_ctrl_state_t state_q, state_d;
  func_t                     func_q, func_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [IMM_WIDTH-1:0]      imm_q, imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_d, alu_result_c;
  logic [CNT_WIDTH-1:0]      cnt_d;
  logic                      ready_d, rd_en_d, wb_valid_d, illegal_d, busy_d;

  alu_math #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_alu_math (
    .func     (func_q),
    .a        (rf_rs1_data_i),
    .b        (rf_rs2_data_i),
    .imm      (imm_q),
    .result_c (alu_result_c)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q         <= IDLE;
      func_q          <= FUNC_ADDI;
      rd_q            <= '0;
      imm_q           <= '0;
      instr_ready_o   <= 1'b1;
      rf_rd_en_o      <= 1'b0;
      rf_rs1_addr_o   <= '0;
      rf_rs2_addr_o   <= '0;
      wb_valid_o      <= 1'b0;
      wb_addr_o       <= '0;
      wb_data_o       <= '0;
      illegal_o       <= 1'b0;
      busy_o          <= 1'b0;
      retired_count_o <= '0;
    end else begin
      state_q         <= state_d;
      func_q          <= func_d;
      rd_q            <= rd_d;
      imm_q           <= imm_d;
      instr_ready_o   <= ready_d;
      rf_rd_en_o      <= rd_en_d;
      rf_rs1_addr_o   <= rs1_d;
      rf_rs2_addr_o   <= rs2_d;
      wb_valid_o      <= wb_valid_d;
      wb_addr_o       <= wb_addr_d;
      wb_data_o       <= wb_data_d;
      illegal_o       <= illegal_d;
      busy_o          <= busy_d;
      retired_count_o <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    rs1_d      = rf_rs1_addr_o;
    rs2_d      = rf_rs2_addr_o;
    wb_addr_d  = wb_addr_o;
    wb_data_d  = wb_data_o;
    cnt_d      = retired_count_o;
    illegal_d  = 1'b0;
    ready_d    = 1'b0;
    rd_en_d    = 1'b0;
    wb_valid_d = 1'b0;
    busy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid_i && instr_ready_o) begin
          func_d = func_i;
          rd_d   = rd_addr_i;
          rs1_d  = rs1_addr_i;
          rs2_d  = rs2_addr_i;
          imm_d  = imm_i;
          if (is_math_func(func_i)) state_d = READ;
          else                      illegal_d = 1'b1;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        wb_data_d = alu_result_c;
        wb_addr_d = rd_q;
        // Writes to x0 are dropped but still retire.
        if (rd_q == '0) begin
          cnt_d   = retired_count_o + CNT_WIDTH'(1);
          state_d = IDLE;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        if (wb_valid_o && wb_ready_i) begin
          cnt_d   = retired_count_o + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status outputs are registered decodes of the next state.
    ready_d    = (state_d == IDLE);
    rd_en_d    = (state_d == READ);
    wb_valid_d = (state_d == WB);
    busy_d     = (state_d != IDLE);
  end

endmodule
